text_pixel_renderer: RTL and testbench

- Consumer side of the character-address interface driven by the time/date text mux.
- Takes {char code, row} ROM address, font size and color index per pixel.
- Fetches the glyph row from an external synchronous font ROM, picks the pixel bit, scales for font size and maps the color index to 12-bit RGB.
- Delays hsync/vsync/video_on so they stay aligned with the pipelined RGB output to the VGA connector.

---
 rtl/text_pixel_renderer.sv | 155 +++++++++++++++
 tb/tb_text_pixel_renderer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/text_pixel_renderer.sv
// Text pixel renderer: font ROM addressing, glyph bit select, 1x/2x/4x scaling and palette
// mapping with syncs delayed to match. Optional blink attribute enabled by TEXT_BLINK_EN.
module text_pixel_renderer #(
    parameter logic [11:0] BG_RGB       = 12'h000,
    parameter int          BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  pixelx,
    input  logic [9:0]  pixely,
    input  logic        video_on,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [10:0] rom_addr,
    input  logic [1:0]  font_size,
    input  logic [3:0]  color_addr,
    output logic [10:0] font_addr,
    input  logic [7:0]  font_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out
);

    function automatic logic [11:0] palette(input logic [3:0] idx);
        case (idx)
            4'd0:  palette = 12'h000;
            4'd1:  palette = 12'hFFF;
            4'd2:  palette = 12'hF00;
            4'd3:  palette = 12'h0F0;
            4'd4:  palette = 12'h00F;
            4'd5:  palette = 12'hFF0;
            4'd6:  palette = 12'h0FF;
            4'd7:  palette = 12'hF0F;
            4'd8:  palette = 12'h444;
            4'd9:  palette = 12'h888;
            4'd10: palette = 12'h800;
            4'd11: palette = 12'h080;
            4'd12: palette = 12'h008;
            4'd13: palette = 12'h880;
            4'd14: palette = 12'h088;
            default: palette = 12'h808;
        endcase
    endfunction

    // The incoming row bits are recomputed from the scaled pixel row.
    logic unused_rom_row;
    assign unused_rom_row = ^rom_addr[3:0];

    logic [1:0] shift_amt;
    logic [9:0] sx;
    logic [9:0] sy;

    assign shift_amt = (font_size == 2'd3) ? 2'd0 : font_size;
    assign sx        = pixelx >> shift_amt;
    assign sy        = pixely >> shift_amt;

    logic [10:0] font_addr_reg;
    logic [2:0]  bitsel_s1_reg, bitsel_s2_reg;
    logic [3:0]  color_s1_reg, color_s2_reg;
    logic        von_s1_reg, von_s2_reg;
    logic [11:0] rgb_reg, rgb_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            font_addr_reg <= '0;
            bitsel_s1_reg <= '0;
            color_s1_reg  <= '0;
            von_s1_reg    <= 1'b0;
            bitsel_s2_reg <= '0;
            color_s2_reg  <= '0;
            von_s2_reg    <= 1'b0;
            rgb_reg       <= '0;
        end else begin
            font_addr_reg <= {rom_addr[10:4], sy[3:0]};
            bitsel_s1_reg <= sx[2:0];
            color_s1_reg  <= color_addr;
            von_s1_reg    <= video_on;
            bitsel_s2_reg <= bitsel_s1_reg;
            color_s2_reg  <= color_s1_reg;
            von_s2_reg    <= von_s1_reg;
            rgb_reg       <= rgb_next;
        end
    end

    assign font_addr = font_addr_reg;
    assign rgb       = rgb_reg;

    // Three-deep delay per sync line; reset holds them inactive (high).
    logic [1:0] sync_in;
    logic [1:0] sync_out;
    assign sync_in = {vsync_in, hsync_in};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [2:0] pipe_reg;
            always_ff @(posedge clk) begin
                if (reset) pipe_reg <= 3'b111;
                else       pipe_reg <= {pipe_reg[1:0], sync_in[gi]};
            end
            assign sync_out[gi] = pipe_reg[2];
        end
    endgenerate

    assign hsync_out = sync_out[0];
    assign vsync_out = sync_out[1];

    logic        pix_on;
    logic [11:0] fg_rgb;
    logic        blink_hide;

    assign pix_on = font_data[3'd7 - bitsel_s2_reg];

`ifdef TEXT_BLINK_EN
    logic       vsync_prev_reg;
    logic [7:0] frame_cnt_reg;
    logic       blink_phase_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            vsync_prev_reg  <= 1'b1;
            frame_cnt_reg   <= '0;
            blink_phase_reg <= 1'b1;
        end else begin
            vsync_prev_reg <= vsync_in;
            if (vsync_prev_reg && !vsync_in) begin
                if (frame_cnt_reg == 8'(BLINK_FRAMES - 1)) begin
                    frame_cnt_reg   <= '0;
                    blink_phase_reg <= ~blink_phase_reg;
                end else begin
                    frame_cnt_reg <= frame_cnt_reg + 8'd1;
                end
            end
        end
    end

    assign fg_rgb     = palette({1'b0, color_s2_reg[2:0]});
    assign blink_hide = color_s2_reg[3] && !blink_phase_reg;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    assign fg_rgb     = palette(color_s2_reg);
    assign blink_hide = 1'b0;
`endif

    always_comb begin
        rgb_next = 12'h000;
        if (!von_s2_reg)
            rgb_next = 12'h000;
        else if (pix_on && !blink_hide)
            rgb_next = fg_rgb;
        else
            rgb_next = BG_RGB;
    end

endmodule

// File: tb/tb_text_pixel_renderer.sv
// Scoreboard bench for text_pixel_renderer: directed pixel vectors with hand-computed colours,
// reset behaviour and 3-clk sync alignment.
module tb_text_pixel_renderer;

    localparam logic [11:0] BG = 12'h123;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [9:0]  pixelx = '0, pixely = '0;
    logic        video_on = 1'b0, hsync_in = 1'b1, vsync_in = 1'b1;
    logic [10:0] rom_addr = '0;
    logic [1:0]  font_size = '0;
    logic [3:0]  color_addr = '0;
    logic [10:0] font_addr;
    logic [7:0]  font_data = '0;
    logic [11:0] rgb;
    logic        hsync_out, vsync_out;

    text_pixel_renderer #(.BG_RGB(BG), .BLINK_FRAMES(2)) dut (
        .clk(clk), .reset(reset), .pixelx(pixelx), .pixely(pixely),
        .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rom_addr(rom_addr), .font_size(font_size), .color_addr(color_addr),
        .font_addr(font_addr), .font_data(font_data), .rgb(rgb),
        .hsync_out(hsync_out), .vsync_out(vsync_out)
    );

    always #5 clk = ~clk;

    // Synchronous font ROM model with two populated rows.
    always @(posedge clk) begin
        case (font_addr)
            11'h315: font_data <= 8'b0010_0000;
            11'h7FF: font_data <= 8'hFF;
            default: font_data <= 8'h00;
        endcase
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int tgt; logic [11:0] rgb; logic hs; logic vs; } out_t;
    typedef struct { int tgt; logic [10:0] fa; } fa_t;
    out_t out_q[$];
    fa_t  fa_q[$];

    int errors = 0;
    int checks = 0;

    always @(negedge clk) begin
        while (out_q.size() > 0 && out_q[0].tgt <= cyc) begin
            automatic out_t e = out_q.pop_front();
            checks++;
            if (e.tgt != cyc || rgb !== e.rgb || hsync_out !== e.hs || vsync_out !== e.vs) begin
                errors++;
                $display("FAIL out cyc=%0d tgt=%0d rgb=%h hs=%b vs=%b required rgb=%h hs=%b vs=%b",
                         cyc, e.tgt, rgb, hsync_out, vsync_out, e.rgb, e.hs, e.vs);
            end
        end
        while (fa_q.size() > 0 && fa_q[0].tgt <= cyc) begin
            automatic fa_t f = fa_q.pop_front();
            checks++;
            if (f.tgt != cyc || font_addr !== f.fa) begin
                errors++;
                $display("FAIL font_addr cyc=%0d got=%h required=%h", cyc, font_addr, f.fa);
            end
        end
    end

    typedef struct {
        logic [9:0] x; logic [9:0] y; logic [10:0] ra; logic [1:0] fs;
        logic [3:0] col; logic von; logic [11:0] rgb; logic [10:0] fa;
    } vec_t;
    vec_t vecs[$];

    task automatic add(input logic [9:0] x, input logic [9:0] y, input logic [10:0] ra,
                       input logic [1:0] fs, input logic [3:0] col, input logic von,
                       input logic [11:0] exp_rgb, input logic [10:0] exp_fa);
        vec_t v;
        v.x = x; v.y = y; v.ra = ra; v.fs = fs; v.col = col; v.von = von;
        v.rgb = exp_rgb; v.fa = exp_fa;
        vecs.push_back(v);
    endtask

    task automatic push_out(input int tgt, input logic [11:0] r, input logic h, input logic v);
        out_t e;
        e.tgt = tgt; e.rgb = r; e.hs = h; e.vs = v;
        out_q.push_back(e);
    endtask

    task automatic push_fa(input int tgt, input logic [10:0] a);
        fa_t f;
        f.tgt = tgt; f.fa = a;
        fa_q.push_back(f);
    endtask

    initial begin
        //   x     y     rom_addr fs  col  von  rgb      font_addr
        add(2,    5,    11'h310, 0,  2,   1,   12'hF00, 11'h315);
        add(3,    5,    11'h31F, 0,  2,   1,   BG,      11'h315);
        add(2,    5,    11'h310, 0,  2,   0,   12'h000, 11'h315);
        add(4,    10,   11'h310, 1,  4,   1,   12'h00F, 11'h315);
        add(5,    10,   11'h317, 1,  4,   1,   12'h00F, 11'h315);
        add(6,    10,   11'h310, 1,  4,   1,   BG,      11'h315);
        add(2,    5,    11'h310, 3,  10,  1,   12'h800, 11'h315);
        add(4,    10,   11'h310, 3,  10,  1,   BG,      11'h31A);
        add(8,    20,   11'h310, 2,  9,   1,   12'h888, 11'h315);
        add(11,   23,   11'h310, 2,  15,  1,   12'h808, 11'h315);
        add(10,   21,   11'h310, 0,  1,   1,   12'hFFF, 11'h315);
        add(1023, 1023, 11'h7F0, 2,  13,  1,   12'h880, 11'h7FF);
        add(1023, 1023, 11'h7F5, 0,  0,   1,   12'h000, 11'h7FF);
        add(1023, 1023, 11'h7F0, 1,  14,  1,   12'h088, 11'h7FF);
        add(2,    5,    11'h310, 0,  3,   1,   12'h0F0, 11'h315);
        add(2,    5,    11'h310, 0,  5,   1,   12'hFF0, 11'h315);
        add(2,    5,    11'h310, 0,  6,   1,   12'h0FF, 11'h315);
        add(2,    5,    11'h310, 0,  7,   1,   12'hF0F, 11'h315);
        add(2,    5,    11'h310, 0,  8,   1,   12'h444, 11'h315);
        add(2,    5,    11'h310, 0,  11,  1,   12'h080, 11'h315);
        add(2,    5,    11'h310, 0,  12,  1,   12'h008, 11'h315);
        add(7,    5,    11'h310, 0,  12,  1,   BG,      11'h315);

        // Reset held 4 clk with a lit pixel and active syncs on the inputs.
        reset = 1'b1;
        pixelx = 2; pixely = 5; rom_addr = 11'h310; font_size = 0; color_addr = 2;
        video_on = 1'b1; hsync_in = 1'b0; vsync_in = 1'b0;
        @(posedge clk); #1;
        for (int t = 0; t < 6; t++) push_out(cyc + t, 12'h000, 1'b1, 1'b1);
        for (int t = 0; t < 4; t++) push_fa(cyc + t, 11'h000);
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b0;

        foreach (vecs[i]) begin
            logic h, v;
            h = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            pixelx = vecs[i].x; pixely = vecs[i].y; rom_addr = vecs[i].ra;
            font_size = vecs[i].fs; color_addr = vecs[i].col; video_on = vecs[i].von;
            hsync_in = h; vsync_in = v;
            push_out(cyc + 3, vecs[i].rgb, h, v);
            push_fa(cyc + 1, vecs[i].fa);
            @(posedge clk); #1;
        end

        // Blanked region with random sync toggling.
        for (int i = 0; i < 24; i++) begin
            logic h, v;
            h = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            video_on = 1'b0; hsync_in = h; vsync_in = v;
            pixelx = 10'($urandom_range(0, 1023)); pixely = 10'($urandom_range(0, 1023));
            push_out(cyc + 3, 12'h000, h, v);
            @(posedge clk); #1;
        end

        hsync_in = 1'b1; vsync_in = 1'b1;
        for (int t = 0; t < 50 && (out_q.size() > 0 || fa_q.size() > 0); t++) begin
            @(posedge clk); #1;
        end
        if (out_q.size() > 0 || fa_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout pending=%0d required=0", out_q.size() + fa_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
